// File: rtl/cp0_exc_unit.sv
// -----------------------------------------------------------------------------
// cp0_exc_unit
//
// M-stage exception unit with the CP0 state it depends on. It picks the
// highest-priority exception for the instruction in M, drives the pipeline
// flush and redirect PC, and commits Status/Cause/EPC/BadVAddr on the clock
// edge. It also owns the Count/Compare timer, the hardware interrupt
// synchroniser and the MTC0/MFC0 register port.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   ext_int           asynchronous hardware interrupt requests
//   stallM            M stage stalled: no exception or MTC0 commit this cycle
//   pcM               PC of the M-stage instruction
//   in_delayslotM     M-stage instruction sits in a branch delay slot
//   alu_outM          data address, captured into BadVAddr on load/store faults
//   ri .. eretM       exception flags raised for the M-stage instruction
//   cp0_we/waddr/wdata  MTC0 write port
//   cp0_raddr/rdata   MFC0 read port (combinational, pre-edge values)
//   except_type       ExcCode zero-extended, 32'he for ERET, 0 for none
//   flush_exception   flush the pipeline this cycle
//   pc_exception      redirect target (EPC for ERET, vector otherwise)
//   status_o, cause_o, epc_o  current register values
//   timer_int_o       Cause.TI
//
// Handshake note: there is no valid/ready traffic here. An exception "fires"
// on a cycle where it is selected and stallM is low; that same condition is
// the commit strobe for the CP0 state.
// -----------------------------------------------------------------------------
module cp0_exc_unit #(
    parameter int          NUM_HW_INT     = 6,
    parameter logic [31:0] EXC_VECTOR     = 32'hbfc0_0380,
    parameter int          COUNT_DIV_LOG2 = 1,
    parameter int          TIMER_IP       = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_HW_INT-1:0] ext_int,
    input  logic                  stallM,
    input  logic [31:0]           pcM,
    input  logic                  in_delayslotM,
    input  logic [31:0]           alu_outM,
    input  logic                  ri,
    input  logic                  breakM,
    input  logic                  syscall,
    input  logic                  overflow,
    input  logic                  addrErrorLw,
    input  logic                  addrErrorSw,
    input  logic                  pcError,
    input  logic                  eretM,
    input  logic                  cp0_we,
    input  logic [4:0]            cp0_waddr,
    input  logic [4:0]            cp0_raddr,
    input  logic [31:0]           cp0_wdata,
    output logic [31:0]           cp0_rdata,
    output logic [31:0]           except_type,
    output logic                  flush_exception,
    output logic [31:0]           pc_exception,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o,
    output logic                  timer_int_o
);

    // CP0 register numbers
    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    // ExcCode values
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // A zero-width prescaler is not legal, so keep one bit and ignore it
    // when the divider is 1.
    localparam int PW = (COUNT_DIV_LOG2 > 0) ? COUNT_DIV_LOG2 : 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_HW_INT-1:0] ext_int_q;
    logic [PW-1:0]         presc;

    logic [7:0]  status_im;
    logic        status_exl;
    logic        status_ie;

    logic        cause_bd;
    logic        cause_ti;
    logic [7:2]  cause_ip_hw;   // hardware lines (plus timer), refreshed every cycle
    logic [1:0]  cause_ip_sw;   // software interrupt bits, MTC0-writable
    logic [4:0]  cause_exc;

    logic [31:0] epc;
    logic [31:0] badvaddr;
    logic [31:0] count;
    logic [31:0] compare;

    // ------------------------------------------------------------------
    // Architectural views of Status and Cause
    // ------------------------------------------------------------------
    // Status: BEV (bit 22) is fixed at 1; only IM, EXL and IE are stored.
    assign status_o = {9'd0, 1'b1, 6'd0, status_im, 6'd0, status_exl, status_ie};
    assign cause_o  = {cause_bd, cause_ti, 14'd0, cause_ip_hw, cause_ip_sw,
                       1'b0, cause_exc, 2'b00};
    assign epc_o       = epc;
    assign timer_int_o = cause_ti;

    logic [7:0] ip_all;
    logic       int_pending;

    assign ip_all      = {cause_ip_hw, cause_ip_sw};
    assign int_pending = status_ie & ~status_exl & (|(status_im & ip_all));

    // ------------------------------------------------------------------
    // Exception prioritisation
    // ------------------------------------------------------------------
    // exc_valid is kept separate from except_type because an interrupt has
    // ExcCode 0, which on except_type is indistinguishable from "none".
    logic       exc_valid;
    logic       exc_eret;
    logic [4:0] exc_code;

    always_comb begin
        exc_valid = 1'b0;
        exc_eret  = 1'b0;
        exc_code  = EXC_INT;
        if (!rst) begin
            if (int_pending) begin
                exc_valid = 1'b1;
                exc_code  = EXC_INT;
            end else if (pcError) begin
                exc_valid = 1'b1;
                exc_code  = EXC_ADEL;
            end else if (ri) begin
                exc_valid = 1'b1;
                exc_code  = EXC_RI;
            end else if (overflow) begin
                exc_valid = 1'b1;
                exc_code  = EXC_OV;
            end else if (syscall) begin
                exc_valid = 1'b1;
                exc_code  = EXC_SYS;
            end else if (breakM) begin
                exc_valid = 1'b1;
                exc_code  = EXC_BP;
            end else if (eretM) begin
                exc_valid = 1'b1;
                exc_eret  = 1'b1;
            end else if (addrErrorLw) begin
                exc_valid = 1'b1;
                exc_code  = EXC_ADEL;
            end else if (addrErrorSw) begin
                exc_valid = 1'b1;
                exc_code  = EXC_ADES;
            end
        end
    end

    always_comb begin
        except_type = 32'd0;
        if (exc_valid) begin
            except_type = exc_eret ? 32'h0000_000e : {27'd0, exc_code};
        end
    end

    assign flush_exception = exc_valid & ~stallM;

    always_comb begin
        pc_exception = 32'd0;
        if (exc_valid) begin
            pc_exception = exc_eret ? epc : EXC_VECTOR;
        end
    end

    // ------------------------------------------------------------------
    // Commit strobes
    // ------------------------------------------------------------------
    logic exc_commit;
    logic eret_commit;
    logic mtc0_commit;

    assign exc_commit  = flush_exception & ~exc_eret;
    assign eret_commit = flush_exception & exc_eret;
    // Any selected exception (even a stalled one) blocks the MTC0.
    assign mtc0_commit = cp0_we & ~stallM & ~exc_valid;

    // ------------------------------------------------------------------
    // Count / Compare / TI
    // ------------------------------------------------------------------
    logic          count_tick;
    logic [PW-1:0] presc_next;
    logic          count_wr;
    logic          compare_wr;
    logic [31:0]   count_next;
    logic          ti_next;

    assign count_tick = (COUNT_DIV_LOG2 == 0) ? 1'b1 : (presc == {PW{1'b1}});
    assign presc_next = (COUNT_DIV_LOG2 == 0) ? '0 : presc + PW'(1);
    assign count_wr   = mtc0_commit & (cp0_waddr == REG_COUNT);
    assign compare_wr = mtc0_commit & (cp0_waddr == REG_COMPARE);

    always_comb begin
        count_next = count + {31'd0, count_tick};
        if (count_wr) begin
            count_next = cp0_wdata;
        end
    end

    // The match is only evaluated when Count actually moves (tick or write).
    // Otherwise the reset state Count == Compare == 0 would raise TI at once.
    always_comb begin
        ti_next = cause_ti;
        if (compare_wr) begin
            ti_next = 1'b0;
        end else if ((count_tick | count_wr) && (count_next == compare)) begin
            ti_next = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Hardware IP bits: synchronised lines, timer folded into TIMER_IP
    // ------------------------------------------------------------------
    logic [5:0] ext_q6;
    logic [7:2] ip_hw_next;

    always_comb begin
        ext_q6 = '0;
        ext_q6[NUM_HW_INT-1:0] = ext_int_q;
        ip_hw_next = ext_q6;
        if (TIMER_IP >= 2) begin
            ip_hw_next[TIMER_IP] = ip_hw_next[TIMER_IP] | ti_next;
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_int_q   <= '0;
            presc       <= '0;
            status_im   <= 8'd0;
            status_exl  <= 1'b0;
            status_ie   <= 1'b0;
            cause_bd    <= 1'b0;
            cause_ti    <= 1'b0;
            cause_ip_hw <= 6'd0;
            cause_ip_sw <= 2'd0;
            cause_exc   <= 5'd0;
            epc         <= 32'd0;
            badvaddr    <= 32'd0;
            count       <= 32'd0;
            compare     <= 32'd0;
        end else begin
            // These advance regardless of stallM.
            ext_int_q   <= ext_int;
            presc       <= presc_next;
            count       <= count_next;
            cause_ti    <= ti_next;
            cause_ip_hw <= ip_hw_next;

            if (compare_wr) begin
                compare <= cp0_wdata;
            end

            if (mtc0_commit) begin
                case (cp0_waddr)
                    REG_STATUS: begin
                        status_im  <= cp0_wdata[15:8];
                        status_exl <= cp0_wdata[1];
                        status_ie  <= cp0_wdata[0];
                    end
                    REG_CAUSE: cause_ip_sw <= cp0_wdata[9:8];
                    REG_EPC:   epc         <= cp0_wdata;
                    default:   ;
                endcase
            end

            if (exc_commit) begin
                // A nested exception (EXL already set) keeps the original
                // return point so ERET goes back to the first fault.
                if (!status_exl) begin
                    epc      <= in_delayslotM ? (pcM - 32'd4) : pcM;
                    cause_bd <= in_delayslotM;
                end
                status_exl <= 1'b1;
                cause_exc  <= exc_code;
                if ((exc_code == EXC_ADEL) || (exc_code == EXC_ADES)) begin
                    badvaddr <= pcError ? pcM : alu_outM;
                end
            end

            if (eret_commit) begin
                status_exl <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // MFC0 read port (no write bypass)
    // ------------------------------------------------------------------
    always_comb begin
        case (cp0_raddr)
            REG_BADVADDR: cp0_rdata = badvaddr;
            REG_COUNT:    cp0_rdata = count;
            REG_COMPARE:  cp0_rdata = compare;
            REG_STATUS:   cp0_rdata = status_o;
            REG_CAUSE:    cp0_rdata = cause_o;
            REG_EPC:      cp0_rdata = epc;
            default:      cp0_rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_unit.sv
module tb_cp0_exc_unit;

    localparam int          NHW  = 6;
    localparam logic [31:0] VEC  = 32'hbfc0_0380;
    localparam int          DIV  = 1;
    localparam int          TIP  = 7;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [NHW-1:0] ext_int;
    logic        stallM, in_delayslotM;
    logic [31:0] pcM, alu_outM;
    logic        ri, breakM, syscall, overflow, addrErrorLw, addrErrorSw, pcError, eretM;
    logic        cp0_we;
    logic [4:0]  cp0_waddr, cp0_raddr;
    logic [31:0] cp0_wdata, cp0_rdata, except_type, pc_exception;
    logic        flush_exception, timer_int_o;
    logic [31:0] status_o, cause_o, epc_o;

    cp0_exc_unit #(
        .NUM_HW_INT(NHW), .EXC_VECTOR(VEC), .COUNT_DIV_LOG2(DIV), .TIMER_IP(TIP)
    ) dut (
        .clk(clk), .rst(rst), .ext_int(ext_int), .stallM(stallM), .pcM(pcM),
        .in_delayslotM(in_delayslotM), .alu_outM(alu_outM), .ri(ri), .breakM(breakM),
        .syscall(syscall), .overflow(overflow), .addrErrorLw(addrErrorLw),
        .addrErrorSw(addrErrorSw), .pcError(pcError), .eretM(eretM),
        .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_raddr(cp0_raddr),
        .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata), .except_type(except_type),
        .flush_exception(flush_exception), .pc_exception(pc_exception),
        .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .timer_int_o(timer_int_o)
    );

    // ---------------- scoreboard counters ----------------
    int n_tests = 0;
    int n_fail  = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Registers are kept as whole architectural words and updated with
    // field masks, following the register descriptions directly.
    logic [31:0]    m_status, m_cause, m_epc, m_badv, m_count, m_compare;
    logic [NHW-1:0] m_ext_q;
    int             m_phase;   // cycles since last Count tick, modulo 2^DIV

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_badv;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    // Walk the priority list and report the first raised cause.
    task automatic m_classify(output bit v, output bit er, output logic [4:0] code);
        bit flags[9];
        int codes[9];
        bit ip;
        ip = m_status[0] && !m_status[1] && ((m_status[15:8] & m_cause[15:8]) != 8'd0);
        flags = '{ip, pcError, ri, overflow, syscall, breakM, eretM, addrErrorLw, addrErrorSw};
        codes = '{0, 4, 10, 12, 8, 9, 14, 4, 5};
        v = 1'b0; er = 1'b0; code = 5'd0;
        if (!rst) begin
            for (int i = 0; i < 9; i++) begin
                if (!v && flags[i]) begin
                    v    = 1'b1;
                    er   = (i == 6);
                    code = 5'(codes[i]);
                end
            end
        end
    endtask

    task automatic model_edge();
        bit v, er, tick, cnt_wr, mtc0, ti;
        logic [4:0] code;
        logic [31:0] old_compare;
        if (rst) begin
            m_status = 32'h0040_0000; m_cause = 0; m_epc = 0; m_badv = 0;
            m_count = 0; m_compare = 0; m_ext_q = '0; m_phase = 0;
            return;
        end
        m_classify(v, er, code);
        mtc0 = cp0_we && !stallM && !v;
        // timer
        m_phase = (m_phase + 1) % (1 << DIV);
        tick    = (m_phase == 0);
        cnt_wr  = mtc0 && (cp0_waddr == 5'd9);
        if (cnt_wr) m_count = cp0_wdata;
        else if (tick) m_count = m_count + 1;
        old_compare = m_compare;
        ti = m_cause[30];
        if (mtc0 && cp0_waddr == 5'd11) ti = 1'b0;
        else if ((tick || cnt_wr) && m_count == old_compare) ti = 1'b1;
        m_cause[30] = ti;
        // interrupt lines arrive two edges after being driven
        m_cause[15:10] = 6'(m_ext_q);
        m_cause[8 + TIP] = m_cause[8 + TIP] | ti;
        m_ext_q = ext_int;
        // exception commit
        if (v && !stallM && !er) begin
            if (!m_status[1]) begin
                m_epc = in_delayslotM ? pcM - 32'd4 : pcM;
                m_cause[31] = in_delayslotM;
            end
            m_status[1] = 1'b1;
            m_cause[6:2] = code;
            if (code == 5'd4 || code == 5'd5) m_badv = pcError ? pcM : alu_outM;
        end
        if (v && !stallM && er) m_status[1] = 1'b0;
        if (mtc0) begin
            case (cp0_waddr)
                5'd11: m_compare = cp0_wdata;
                5'd12: m_status = (m_status & ~32'h0000_ff03) | (cp0_wdata & 32'h0000_ff03);
                5'd13: m_cause[9:8] = cp0_wdata[9:8];
                5'd14: m_epc = cp0_wdata;
                default: ;
            endcase
        end
    endtask

    // Per-cycle comparison of every output against the model.
    task automatic check_cycle();
        bit v, er;
        logic [4:0] code;
        logic [31:0] e_type, e_pc;
        m_classify(v, er, code);
        e_type = !v ? 32'd0 : (er ? 32'h0000_000e : {27'd0, code});
        e_pc   = !v ? 32'd0 : (er ? m_epc : VEC);
        chk("except_type", except_type, e_type);
        chk("flush", {31'd0, flush_exception}, {31'd0, v && !stallM});
        chk("pc_exception", pc_exception, e_pc);
        chk("status", status_o, m_status);
        chk("cause", cause_o, m_cause);
        chk("epc", epc_o, m_epc);
        chk("timer_int", {31'd0, timer_int_o}, {31'd0, m_cause[30]});
        chk("rdata", cp0_rdata, m_read(cp0_raddr));
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        if (checking) check_cycle();
        @(posedge clk);
        model_edge();
        checking = 1'b1;
        #1;
    endtask

    task automatic clear_inputs();
        ext_int = '0; stallM = 0; in_delayslotM = 0; pcM = 0; alu_outM = 0;
        ri = 0; breakM = 0; syscall = 0; overflow = 0; addrErrorLw = 0;
        addrErrorSw = 0; pcError = 0; eretM = 0; cp0_we = 0; cp0_waddr = 0;
        cp0_wdata = 0; cp0_raddr = 0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        cp0_we = 1; cp0_waddr = a; cp0_wdata = d;
        step();
        cp0_we = 0;
    endtask

    task automatic do_eret(input logic [31:0] exp_target);
        eretM = 1; #1;
        chk("eret_target", pc_exception, exp_target);
        step();
        eretM = 0;
        chk("eret_exl_clear", {31'd0, status_o[1]}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int budget;
        clear_inputs();
        rst = 1;
        model_edge();

        // Reset gates exception outputs even with flags raised.
        overflow = 1; syscall = 1; eretM = 1;
        repeat (3) step();
        #1;
        chk("rst_flush", {31'd0, flush_exception}, 32'd0);
        chk("rst_type", except_type, 32'd0);
        clear_inputs();
        rst = 0;

        // Idle: Count advances once per two cycles.
        repeat (10) step();
        cp0_raddr = 5'd9; #1;
        chk("idle_status", status_o, 32'h0040_0000);
        chk("idle_cause", cause_o, 32'd0);
        chk("idle_count", cp0_rdata, 32'd5);

        // Overflow in a delay slot.
        overflow = 1; pcM = 32'hbfc0_1000; in_delayslotM = 1; #1;
        chk("ov_flush", {31'd0, flush_exception}, 32'd1);
        chk("ov_pc", pc_exception, 32'hbfc0_0380);
        chk("ov_type", except_type, 32'd12);
        step();
        overflow = 0; in_delayslotM = 0;
        chk("ov_epc", epc_o, 32'hbfc0_0ffc);
        chk("ov_bd", {31'd0, cause_o[31]}, 32'd1);
        chk("ov_exccode", {27'd0, cause_o[6:2]}, 32'd12);
        chk("ov_exl", {31'd0, status_o[1]}, 32'd1);
        do_eret(32'hbfc0_0ffc);

        // syscall outranks a load address error; BadVAddr untouched.
        addrErrorLw = 1; syscall = 1; alu_outM = 32'h8000_0003; pcM = 32'hbfc0_1100; #1;
        chk("sys_type", except_type, 32'd8);
        step();
        syscall = 0; cp0_raddr = 5'd8; #1;
        chk("sys_badv", cp0_rdata, 32'd0);
        chk("adel_type", except_type, 32'd4);
        step();
        addrErrorLw = 0; #1;
        chk("adel_badv", cp0_rdata, 32'h8000_0003);
        do_eret(32'hbfc0_1100);

        // Hardware interrupt via ext_int[0].
        mtc0(5'd12, 32'h0000_0401);
        ext_int = 6'b000001;
        step();
        ext_int = '0; pcM = 32'hbfc0_2000;
        chk("int_ip_early", {31'd0, cause_o[10]}, 32'd0);
        step();
        chk("int_ip_set", {31'd0, cause_o[10]}, 32'd1);
        chk("int_flush", {31'd0, flush_exception}, 32'd1);
        chk("int_type", except_type, 32'd0);
        chk("int_pc", pc_exception, VEC);
        step();
        chk("int_epc", epc_o, 32'hbfc0_2000);
        chk("int_exccode", {27'd0, cause_o[6:2]}, 32'd0);
        overflow = 1; pcM = 32'hbfc0_3000;
        step();
        overflow = 0;
        chk("nested_epc", epc_o, 32'hbfc0_2000);
        chk("nested_exccode", {27'd0, cause_o[6:2]}, 32'd12);
        do_eret(32'hbfc0_2000);

        // Timer: Compare=20 with Count=10.
        mtc0(5'd9, 32'd10);
        mtc0(5'd11, 32'd20);
        budget = 60;
        while (!timer_int_o && budget > 0) begin step(); budget--; end
        cp0_raddr = 5'd9; #1;
        chk("ti_set", {31'd0, timer_int_o}, 32'd1);
        chk("ti_ip7", {31'd0, cause_o[15]}, 32'd1);
        chk("ti_count", cp0_rdata, 32'd20);
        mtc0(5'd11, 32'd30);
        chk("ti_clear", {31'd0, timer_int_o}, 32'd0);
        // Rewrite Compare exactly on the cycle Count would reach 30.
        budget = 60;
        while (!(m_count == 32'd29 && m_phase == (1 << DIV) - 1) && budget > 0) begin
            step(); budget--;
        end
        chk("ti_wait_budget", {31'd0, budget > 0}, 32'd1);
        mtc0(5'd11, 32'd50);
        #1;
        chk("ti_race", {31'd0, timer_int_o}, 32'd0);
        chk("ti_race_count", cp0_rdata, 32'd30);

        // Stall holds both the exception and the MTC0.
        stallM = 1; breakM = 1; cp0_we = 1; cp0_waddr = 5'd14;
        cp0_wdata = 32'h1234_5678; pcM = 32'h0000_2000; #1;
        chk("stall_flush", {31'd0, flush_exception}, 32'd0);
        step();
        chk("stall_epc", epc_o, 32'hbfc0_2000);
        stallM = 0; #1;
        chk("unstall_flush", {31'd0, flush_exception}, 32'd1);
        chk("unstall_type", except_type, 32'd9);
        step();
        clear_inputs();
        chk("unstall_epc", epc_o, 32'h0000_2000);
        do_eret(32'h0000_2000);

        // Randomised traffic against the model.
        for (int n = 0; n < 2500; n++) begin
            int sel;
            rst           = ($urandom_range(0, 499) == 0);
            stallM        = ($urandom_range(0, 3) == 0);
            pcM           = {$urandom} & 32'hffff_fffc;
            alu_outM      = $urandom;
            in_delayslotM = $urandom_range(0, 1);
            pcError       = ($urandom_range(0, 29) == 0);
            ri            = ($urandom_range(0, 29) == 0);
            overflow      = ($urandom_range(0, 29) == 0);
            syscall       = ($urandom_range(0, 29) == 0);
            breakM        = ($urandom_range(0, 29) == 0);
            eretM         = ($urandom_range(0, 12) == 0);
            addrErrorLw   = ($urandom_range(0, 29) == 0);
            addrErrorSw   = ($urandom_range(0, 29) == 0);
            for (int b = 0; b < NHW; b++) ext_int[b] = ($urandom_range(0, 39) == 0);
            cp0_raddr     = 5'($urandom_range(0, 15));
            cp0_we        = ($urandom_range(0, 4) == 0);
            sel           = $urandom_range(0, 6);
            case (sel)
                0: cp0_waddr = 5'd8;
                1: cp0_waddr = 5'd9;
                2: cp0_waddr = 5'd11;
                3: cp0_waddr = 5'd12;
                4: cp0_waddr = 5'd13;
                5: cp0_waddr = 5'd14;
                default: cp0_waddr = 5'($urandom_range(0, 31));
            endcase
            cp0_wdata = $urandom;
            if (cp0_waddr == 5'd11) cp0_wdata = m_count + 32'($urandom_range(0, 4));
            step();
        end

        clear_inputs();
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
